pipeline_stall_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipelined CPU with data cache. Sits directly downstream of `Hazard_Detection` and merges three inputs:
- the load-use stall it produces;
- the branch flush from ID;
- the multi-cycle data-cache handshake from MEM.

It drives per-stage register enables and bubbles, holds the cache request until acknowledge, and keeps saturating stall/flush performance counters.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 12 +
 rtl/pipeline_stall_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_stall_ctrl.sv | 88 ++++++++
 tb/tb_pipeline_stall_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared CPU constants for the stall/flush controller: FSM encodings and
// the default performance-counter width.
package pipeline_stall_ctrl_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller: merges load-use stall, ID branch flush and
// the data-cache handshake into per-stage enables, plus stall counters.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hz_stall_i,
    input  logic             hz_noop_i,
    input  logic             hz_pcwrite_i,
    input  logic             flush_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             mem_enable_o,
    output logic             pc_we_o,
    output logic             if_id_we_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             pipe_we_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] loaduse_cnt_o,
    output logic [CNT_W-1:0] memwait_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_e state;
    logic   lu;
    logic   mstall;
    logic   run;

    always_comb begin
        lu     = hz_stall_i | hz_noop_i | ~hz_pcwrite_i;
        mstall = (state == WAIT) ? ~mem_ack_i : (mem_req_i & ~mem_ack_i);
        // A cache freeze outranks everything; lu/flush are re-evaluated after release.
        run    = ~rst_i & ~mstall;

        mem_enable_o   = ~rst_i & ((state == WAIT) | mem_req_i);
        pc_we_o        = run & ~lu;
        if_id_we_o     = run & ~lu;
        pipe_we_o      = run;
        id_ex_bubble_o = run & lu;
        // Branch operands are stale during a load-use stall, so the flush waits.
        if_id_flush_o  = run & ~lu & flush_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (mstall)    state <= WAIT;
                WAIT:    if (mem_ack_i) state <= IDLE;
                default:                state <= IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (mstall | lu),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_memwait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (mstall),
        .cnt_o (memwait_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_loaduse_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (lu & ~mstall),
        .cnt_o (loaduse_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (if_id_flush_o),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a rule-level model (32-bit and 3-bit counter copies).
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic hs = 1'b0, hn = 1'b0, pw = 1'b1, fl = 1'b0, req = 1'b0, ack = 1'b0;

    logic        men, pcwe, ifwe, iffl, bub, pwe;
    logic [31:0] c_stall, c_lu, c_mw, c_fl;
    logic        s_men, s_pcwe, s_ifwe, s_iffl, s_bub, s_pwe;
    logic [2:0]  s_stall, s_lu, s_mw, s_fl;

    pipeline_stall_ctrl #(.CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .hz_stall_i(hs), .hz_noop_i(hn), .hz_pcwrite_i(pw),
        .flush_i(fl), .mem_req_i(req), .mem_ack_i(ack),
        .mem_enable_o(men), .pc_we_o(pcwe), .if_id_we_o(ifwe), .if_id_flush_o(iffl),
        .id_ex_bubble_o(bub), .pipe_we_o(pwe),
        .stall_cnt_o(c_stall), .loaduse_cnt_o(c_lu), .memwait_cnt_o(c_mw), .flush_cnt_o(c_fl)
    );

    pipeline_stall_ctrl #(.CNT_W(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .hz_stall_i(hs), .hz_noop_i(hn), .hz_pcwrite_i(pw),
        .flush_i(fl), .mem_req_i(req), .mem_ack_i(ack),
        .mem_enable_o(s_men), .pc_we_o(s_pcwe), .if_id_we_o(s_ifwe), .if_id_flush_o(s_iffl),
        .id_ex_bubble_o(s_bub), .pipe_we_o(s_pwe),
        .stall_cnt_o(s_stall), .loaduse_cnt_o(s_lu), .memwait_cnt_o(s_mw), .flush_cnt_o(s_fl)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: 'pend' = an issued cache request still awaiting its ack.
    // Counters are plain integers clamped at 2^W-1.
    bit     pend = 1'b0;
    longint m_stall = 0, m_lu = 0, m_mw = 0, m_fl = 0;
    longint n_stall = 0, n_lu = 0, n_mw = 0, n_fl = 0;
    localparam longint MAX32 = 64'hFFFF_FFFF;
    localparam longint MAX3  = 7;

    function automatic longint sat(input longint v, input longint mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    always @(negedge clk) begin
        bit e_lu, e_ms, e_men, e_pc, e_pipe, e_bub, e_fl;
        e_lu  = hs | hn | ~pw;
        e_ms  = pend ? ~ack : (req & ~ack);
        e_men = !rst && (pend || req);
        e_pipe = !rst && !e_ms;
        e_pc  = e_pipe && !e_lu;
        e_bub = e_pipe && e_lu;
        e_fl  = e_pc && fl;

        chk("mem_enable", men, e_men);
        chk("pc_we", pcwe, e_pc);
        chk("if_id_we", ifwe, e_pc);
        chk("pipe_we", pwe, e_pipe);
        chk("bubble", bub, e_bub);
        chk("if_id_flush", iffl, e_fl);
        chk("stall_cnt", c_stall, m_stall);
        chk("loaduse_cnt", c_lu, m_lu);
        chk("memwait_cnt", c_mw, m_mw);
        chk("flush_cnt", c_fl, m_fl);
        chk("w3_ctrl", {s_men, s_pcwe, s_ifwe, s_iffl, s_bub, s_pwe},
            {e_men, e_pc, e_pc, e_fl, e_bub, e_pipe});
        chk("w3_stall_cnt", s_stall, n_stall);
        chk("w3_loaduse_cnt", s_lu, n_lu);
        chk("w3_memwait_cnt", s_mw, n_mw);
        chk("w3_flush_cnt", s_fl, n_fl);

        // Effects of this cycle, visible after the coming rising edge.
        if (rst) begin
            pend = 1'b0;
            m_stall = 0; m_lu = 0; m_mw = 0; m_fl = 0;
            n_stall = 0; n_lu = 0; n_mw = 0; n_fl = 0;
        end else begin
            pend = e_ms;
            if (e_ms || e_lu) begin m_stall = sat(m_stall, MAX32); n_stall = sat(n_stall, MAX3); end
            if (e_ms)         begin m_mw = sat(m_mw, MAX32);       n_mw = sat(n_mw, MAX3);       end
            if (e_lu && !e_ms) begin m_lu = sat(m_lu, MAX32);      n_lu = sat(n_lu, MAX3);       end
            if (e_fl)         begin m_fl = sat(m_fl, MAX32);       n_fl = sat(n_fl, MAX3);       end
        end
    end

    // Drive one cycle's inputs just after the rising edge, then wait to mid-cycle.
    task automatic cyc(input bit r, input bit luv, input bit f, input bit rq, input bit ak);
        @(posedge clk); #1;
        rst = r; hs = luv; hn = luv; pw = ~luv; fl = f; req = rq; ack = ak;
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        do_reset();
        chk("lit_reset_stall_cnt", c_stall, 0);
        chk("lit_reset_pc_we", pcwe, 1);

        // Load-use, no memory op.
        cyc(0, 1, 0, 0, 0);
        chk("lit_lu_pc_we", pcwe, 0);
        chk("lit_lu_if_id_we", ifwe, 0);
        chk("lit_lu_bubble", bub, 1);
        cyc(0, 0, 0, 0, 0);
        chk("lit_lu_loaduse_cnt", c_lu, 1);
        chk("lit_lu_stall_cnt", c_stall, 1);

        // Cache hit.
        do_reset();
        cyc(0, 0, 0, 1, 1);
        chk("lit_hit_mem_en", men, 1);
        chk("lit_hit_pipe_we", pwe, 1);
        cyc(0, 0, 0, 0, 0);
        chk("lit_hit_memwait", c_mw, 0);
        chk("lit_hit_idle", men, 0);

        // Miss, ack 5 cycles after the request.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk("lit_miss_mem_en", men, 1);
            chk("lit_miss_pipe_we", pwe, 0);
        end
        cyc(0, 0, 0, 1, 1);
        chk("lit_miss_ack_mem_en", men, 1);
        chk("lit_miss_ack_pipe_we", pwe, 1);
        cyc(0, 0, 0, 0, 0);
        chk("lit_miss_memwait", c_mw, 5);
        chk("lit_miss_stall", c_stall, 5);

        // Flush with lu, then flush alone.
        do_reset();
        cyc(0, 1, 1, 0, 0);
        chk("lit_flush_lu_suppressed", iffl, 0);
        cyc(0, 0, 1, 0, 0);
        chk("lit_flush_cnt_unchanged", c_fl, 0);
        chk("lit_flush_alone", iffl, 1);
        cyc(0, 0, 0, 0, 0);
        chk("lit_flush_cnt", c_fl, 1);

        // lu during a miss: frozen, no bubble until released.
        do_reset();
        cyc(0, 1, 0, 1, 0);
        chk("lit_lu_miss_bubble", bub, 0);
        cyc(0, 1, 0, 1, 0);
        chk("lit_lu_miss_bubble2", bub, 0);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 1, 0, 0, 0);
        chk("lit_lu_after_ack_bubble", bub, 1);

        // Reset asserted on the 3rd wait cycle.
        do_reset();
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        chk("lit_rst_wait_mem_en", men, 0);
        cyc(0, 0, 0, 0, 0);
        chk("lit_rst_wait_idle", men, 0);
        chk("lit_rst_wait_cnt", c_mw, 0);

        // 10 miss cycles: 3-bit counter saturates at 7.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);
        chk("lit_sat_memwait3", s_mw, 7);
        chk("lit_sat_memwait32", c_mw, 10);

        // Random traffic; req held stable while a request is outstanding.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit r, l, f, q, a;
            r = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 25);
            f = ($urandom_range(0, 99) < 20);
            q = pend ? 1'b1 : ($urandom_range(0, 99) < 30);
            a = ($urandom_range(0, 99) < 30);
            @(posedge clk); #1;
            rst = r; hs = l; hn = l; fl = f; req = q; ack = a;
            pw = ($urandom_range(0, 99) < 5) ? 1'b0 : ~l;
        end
        @(posedge clk); #1;
        rst = 1'b0; hs = 1'b0; hn = 1'b0; pw = 1'b1; fl = 1'b0; req = 1'b0; ack = 1'b0;
        @(negedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
